// File: rtl/dmemory_stall_if.sv
// Memory-stage request/response bundle for dmemory_stall.
// The pipeline drives the master side and the memory drives the slave side.
interface dmemory_stall_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] aluRes;
  logic [DATA_W-1:0] writedata;
  logic              halt;
  logic [DATA_W-1:0] readData;
  logic              stall;
  logic              done;
  logic              err;
  logic              halted;

  modport master (
    output memRead, memWrite, aluRes, writedata, halt,
    input  readData, stall, done, err, halted
  );

  modport slave (
    input  memRead, memWrite, aluRes, writedata, halt,
    output readData, stall, done, err, halted
  );
endinterface

// File: rtl/dmemory_stall.sv
// Multi-cycle word-addressed data memory that stalls the pipeline for LATENCY cycles per access.
// Define DMEM_ALIGN_CHECK_EN to reject requests whose byte address is odd.
module dmemory_stall #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmemory_stall_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    op_wr;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [DATA_W-1:0]       wdata;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DATA_W-1:0]       rdata;
  logic                    err_q, halted_q;

  logic                    req, conflict, misalign, accept, reject;
  logic                    stall_c, access, acc_wr;
  logic [DEPTH_LOG2-1:0]   acc_idx, acc_wdata_unused_guard;
  logic [DATA_W-1:0]       acc_wdata;
  logic [DEPTH_LOG2-1:0]   in_idx;
  logic                    unused;

  assign in_idx = bus.aluRes[DEPTH_LOG2:1];
  assign unused = ^{bus.aluRes[ADDR_W-1:DEPTH_LOG2+1], bus.aluRes[0], acc_wdata_unused_guard};
  assign acc_wdata_unused_guard = '0;

  always_comb begin
    req      = (bus.memRead | bus.memWrite) & ~bus.halt;
    conflict = bus.memRead & bus.memWrite;
`ifdef DMEM_ALIGN_CHECK_EN
    misalign = bus.aluRes[0];
`else
    misalign = 1'b0;
`endif
    accept   = (state == IDLE) & req & ~conflict & ~misalign & ~rst;
    reject   = (state == IDLE) & req & (conflict | misalign);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    access    = 1'b0;
    acc_wr    = op_wr;
    acc_idx   = idx;
    acc_wdata = wdata;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_c = 1'b1;
          if (LATENCY == 1) begin
            // Single-cycle latency: perform the access straight from the live inputs.
            access    = 1'b1;
            acc_wr    = bus.memWrite;
            acc_idx   = in_idx;
            acc_wdata = bus.writedata;
            state_nxt = DONE;
          end else begin
            cnt_nxt   = 4'(LATENCY - 1);
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt_nxt == 4'd0) begin
          access    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_wr    <= 1'b0;
      idx      <= '0;
      wdata    <= '0;
      rdata    <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      err_q    <= reject;
      halted_q <= bus.halt & (state == IDLE);
      if (accept) begin
        op_wr <= bus.memWrite;
        idx   <= in_idx;
        wdata <= bus.writedata;
      end
      if (access) begin
        if (acc_wr) mem[acc_idx] <= acc_wdata;
        else        rdata        <= mem[acc_idx];
      end
    end
  end

  assign bus.stall    = stall_c & ~rst;
  assign bus.done     = (state == DONE);
  assign bus.err      = err_q;
  assign bus.halted   = halted_q;
  assign bus.readData = rdata;
endmodule

// File: tb/tb_dmemory_stall.sv
// Directed bench for dmemory_stall: a LATENCY=4 instance and a LATENCY=1 instance share clk/rst.
module tb_dmemory_stall;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic finished = 1'b0;

  always #5 clk = ~clk;

  dmemory_stall_if #(.DATA_W(16), .ADDR_W(16)) b4 ();
  dmemory_stall_if #(.DATA_W(16), .ADDR_W(16)) b1 ();

  dmemory_stall #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(4)) u4 (
    .clk(clk), .rst(rst), .bus(b4)
  );
  dmemory_stall #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv4(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    b4.memRead = rd; b4.memWrite = wr; b4.aluRes = a; b4.writedata = d;
  endtask

  task automatic op4(input string tag, input logic rd, input logic wr,
                     input logic [15:0] a, input logic [15:0] d);
    go(); drv4(rd, wr, a, d);
    smp();
    tests++; if (b4.stall !== 1'b1) begin fails++; $error("FAIL %s accept stall: %0b", tag, b4.stall); end
    for (int i = 1; i <= 3; i++) begin
      go();
      if (i == 1) drv4(1'b0, 1'b0, 16'h0020, 16'hDEAD);
      smp();
      tests++; if (b4.stall !== 1'b1) begin fails++; $error("FAIL %s busy stall: %0b", tag, b4.stall); end
      tests++; if (b4.done !== 1'b0) begin fails++; $error("FAIL %s busy done: %0b", tag, b4.done); end
    end
    go(); smp();
    tests++; if (b4.done !== 1'b1) begin fails++; $error("FAIL %s done: %0b", tag, b4.done); end
    tests++; if (b4.stall !== 1'b0) begin fails++; $error("FAIL %s done stall: %0b", tag, b4.stall); end
  endtask

  initial begin
    #200000;
    if (!finished) begin
      tests++;
      fails++;
      $error("FAIL timeout: bench did not complete within the wait limit");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    drv4(1'b0, 1'b0, 16'h0, 16'h0);
    b4.halt = 1'b0;
    b1.memRead = 1'b0; b1.memWrite = 1'b0; b1.aluRes = '0; b1.writedata = '0; b1.halt = 1'b0;
    rst = 1'b1;
    go(); go();
    rst = 1'b0;
    smp();
    tests++;
    if (b4.readData !== 16'h0 || b4.stall !== 1'b0 || b4.done !== 1'b0 ||
        b4.err !== 1'b0 || b4.halted !== 1'b0) begin
      fails++;
      $error("FAIL rst state: readData=%0h stall=%0b done=%0b err=%0b halted=%0b",
             b4.readData, b4.stall, b4.done, b4.err, b4.halted);
    end
    tests++; if (b4.readData !== 16'h0) begin fails++; $error("FAIL rst readData: %0h", b4.readData); end
    tests++; if (b4.stall !== 1'b0) begin fails++; $error("FAIL rst stall: %0b", b4.stall); end
    tests++; if (b4.done !== 1'b0) begin fails++; $error("FAIL rst done: %0b", b4.done); end
    tests++; if (b4.err !== 1'b0) begin fails++; $error("FAIL rst err: %0b", b4.err); end
    tests++; if (b4.halted !== 1'b0) begin fails++; $error("FAIL rst halted: %0b", b4.halted); end

    op4("wr10", 1'b0, 1'b1, 16'h0010, 16'hBEEF);
    op4("rd10", 1'b1, 1'b0, 16'h0010, 16'h0000);
    tests++; if (b4.readData !== 16'hBEEF) begin fails++; $error("FAIL rd10 data: %0h", b4.readData); end

    go(); drv4(1'b1, 1'b1, 16'h0004, 16'h9999);
    smp();
    tests++; if (b4.stall !== 1'b0) begin fails++; $error("FAIL conf stall: %0b", b4.stall); end
    tests++; if (b4.err !== 1'b0) begin fails++; $error("FAIL conf err early: %0b", b4.err); end
    go(); drv4(1'b0, 1'b0, 16'h0, 16'h0);
    smp();
    tests++; if (b4.err !== 1'b1) begin fails++; $error("FAIL conf err: %0b", b4.err); end
    tests++; if (b4.stall !== 1'b0) begin fails++; $error("FAIL conf stall2: %0b", b4.stall); end
    tests++; if (b4.done !== 1'b0) begin fails++; $error("FAIL conf done: %0b", b4.done); end
    go(); smp();
    tests++; if (b4.err !== 1'b0) begin fails++; $error("FAIL conf err pulse: %0b", b4.err); end
    op4("rd04", 1'b1, 1'b0, 16'h0004, 16'h0000);
    tests++; if (b4.readData !== 16'h0000) begin fails++; $error("FAIL rd04 data: %0h", b4.readData); end

    op4("wrwrap", 1'b0, 1'b1, 16'h0810, 16'h7777);
    op4("rdwrap", 1'b1, 1'b0, 16'h0010, 16'h0000);
    tests++; if (b4.readData !== 16'h7777) begin fails++; $error("FAIL wrap data: %0h", b4.readData); end

    op4("wr02", 1'b0, 1'b1, 16'h0002, 16'h5A5A);
`ifdef DMEM_ALIGN_CHECK_EN
    go(); drv4(1'b1, 1'b0, 16'h0003, 16'h0);
    smp();
    tests++; if (b4.stall !== 1'b0) begin fails++; $error("FAIL odd stall: %0b", b4.stall); end
    go(); drv4(1'b0, 1'b0, 16'h0, 16'h0);
    smp();
    tests++; if (b4.err !== 1'b1) begin fails++; $error("FAIL odd err: %0b", b4.err); end
    tests++; if (b4.done !== 1'b0) begin fails++; $error("FAIL odd done: %0b", b4.done); end
`else
    op4("rd03", 1'b1, 1'b0, 16'h0003, 16'h0000);
    tests++; if (b4.readData !== 16'h5A5A) begin fails++; $error("FAIL odd data: %0h", b4.readData); end
`endif

    go(); drv4(1'b0, 1'b1, 16'h0008, 16'h00AA);
    smp();
    tests++; if (b4.stall !== 1'b1) begin fails++; $error("FAIL hlt accept stall: %0b", b4.stall); end
    go(); drv4(1'b0, 1'b0, 16'h0, 16'h0); b4.halt = 1'b1;
    smp();
    tests++; if (b4.stall !== 1'b1) begin fails++; $error("FAIL hlt busy stall: %0b", b4.stall); end
    tests++; if (b4.halted !== 1'b0) begin fails++; $error("FAIL hlt busy halted: %0b", b4.halted); end
    go(); smp();
    go(); smp();
    tests++; if (b4.stall !== 1'b1) begin fails++; $error("FAIL hlt busy stall3: %0b", b4.stall); end
    go(); smp();
    tests++; if (b4.done !== 1'b1) begin fails++; $error("FAIL hlt done: %0b", b4.done); end
    go(); drv4(1'b1, 1'b0, 16'h0008, 16'h0);
    smp();
    tests++; if (b4.stall !== 1'b0) begin fails++; $error("FAIL hlt rd no stall: %0b", b4.stall); end
    go(); smp();
    tests++; if (b4.halted !== 1'b1) begin fails++; $error("FAIL hlt halted: %0b", b4.halted); end
    tests++; if (b4.stall !== 1'b0) begin fails++; $error("FAIL hlt rd no stall2: %0b", b4.stall); end
    tests++; if (b4.done !== 1'b0) begin fails++; $error("FAIL hlt rd no done: %0b", b4.done); end
    go(); smp();
    tests++; if (b4.done !== 1'b0) begin fails++; $error("FAIL hlt rd no done2: %0b", b4.done); end
    go(); drv4(1'b0, 1'b0, 16'h0, 16'h0); b4.halt = 1'b0;
    smp();
    go(); smp();
    tests++; if (b4.halted !== 1'b0) begin fails++; $error("FAIL hlt cleared: %0b", b4.halted); end
    op4("rd08", 1'b1, 1'b0, 16'h0008, 16'h0000);
    tests++; if (b4.readData !== 16'h00AA) begin fails++; $error("FAIL rd08 data: %0h", b4.readData); end

    go(); b1.memWrite = 1'b1; b1.aluRes = 16'h0002; b1.writedata = 16'h1234;
    smp();
    tests++; if (b1.stall !== 1'b1) begin fails++; $error("FAIL l1 wr stall: %0b", b1.stall); end
    tests++; if (b1.done !== 1'b0) begin fails++; $error("FAIL l1 wr done early: %0b", b1.done); end
    go(); b1.memWrite = 1'b0; b1.memRead = 1'b1; b1.writedata = 16'h0;
    smp();
    tests++; if (b1.done !== 1'b1) begin fails++; $error("FAIL l1 wr done: %0b", b1.done); end
    tests++; if (b1.stall !== 1'b0) begin fails++; $error("FAIL l1 wr done stall: %0b", b1.stall); end
    tests++; if (b1.readData !== 16'h0000) begin fails++; $error("FAIL l1 rd not yet: %0h", b1.readData); end
    go();
    smp();
    tests++; if (b1.stall !== 1'b1) begin fails++; $error("FAIL l1 rd stall: %0b", b1.stall); end
    go(); b1.memRead = 1'b0;
    smp();
    tests++; if (b1.done !== 1'b1) begin fails++; $error("FAIL l1 rd done: %0b", b1.done); end
    tests++; if (b1.readData !== 16'h1234) begin fails++; $error("FAIL l1 rd data: %0h", b1.readData); end

    go(); drv4(1'b0, 1'b1, 16'h0006, 16'h5555);
    smp();
    tests++; if (b4.stall !== 1'b1) begin fails++; $error("FAIL rstw stall: %0b", b4.stall); end
    go(); drv4(1'b0, 1'b0, 16'h0, 16'h0);
    smp();
    go(); rst = 1'b1;
    smp();
    go(); rst = 1'b0;
    smp();
    tests++; if (b4.stall !== 1'b0) begin fails++; $error("FAIL rstw stall0: %0b", b4.stall); end
    tests++; if (b4.done !== 1'b0) begin fails++; $error("FAIL rstw done0: %0b", b4.done); end
    tests++; if (b4.readData !== 16'h0000) begin fails++; $error("FAIL rstw readData0: %0h", b4.readData); end
    tests++; if (b4.err !== 1'b0) begin fails++; $error("FAIL rstw err0: %0b", b4.err); end
    tests++; if (b4.halted !== 1'b0) begin fails++; $error("FAIL rstw halted0: %0b", b4.halted); end
    go(); smp();
    tests++; if (b4.done !== 1'b0) begin fails++; $error("FAIL rstw no done: %0b", b4.done); end
    op4("rd06", 1'b1, 1'b0, 16'h0006, 16'h0000);
    tests++; if (b4.readData !== 16'h0000) begin fails++; $error("FAIL rd06 data: %0h", b4.readData); end

    finished = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
